// File: rtl/cordic_ci_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cordic_ci_master                                             |
// | Description : Queues IEEE-754 single-precision angles and feeds them one   |
// |               at a time to a multicycle CORDIC custom-instruction unit,    |
// |               returning each float result over a valid/ready port in       |
// |               operand order.                                               |
// | Ports       : clk, reset (async, active-low), clk_en (global freeze)       |
// |               op_valid/op_ready/op_data      - operand input stream        |
// |               ci_clk_en/ci_start/ci_dataa    - custom-instruction drive    |
// |               ci_done/ci_result              - custom-instruction return   |
// |               res_valid/res_ready/res_data/res_timeout - result stream     |
// |               busy                           - activity indicator          |
// | Options     : define CI_TIMEOUT_EN to abort a WAIT that lasts              |
// |               TIMEOUT_CYCLES cycles, returning quiet NaN with res_timeout. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cordic_ci_master #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [31:0] op_data,
   output logic        ci_clk_en,
   output logic        ci_start,
   output logic [31:0] ci_dataa,
   input  logic        ci_done,
   input  logic [31:0] ci_result,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_timeout,
   output logic        busy
);

   localparam int               PTR_W      = $clog2(DEPTH);
   localparam int               CNT_W      = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [31:0]      QNAN       = 32'h7FC0_0000;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("cordic_ci_master: DEPTH must be a power of two in 2..16");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("cordic_ci_master: TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [31:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             not_empty;
   logic             push;
   logic             pop;
   logic             capture;
   logic             load_dataa;
   logic             timeout_hit;

   assign ci_clk_en = clk_en;
   assign not_empty = (count != '0);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else if (clk_en) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (not_empty) state_nxt = ST_ISSUE;
         // A unit that answers in the issue cycle skips WAIT entirely.
         ST_ISSUE: state_nxt = ci_done ? ST_HOLD : ST_WAIT;
         ST_WAIT:  if (ci_done || timeout_hit) state_nxt = ST_HOLD;
         // The head was already popped on capture, so count reflects what
         // is still waiting to be issued.
         ST_HOLD:  if (res_ready) state_nxt = not_empty ? ST_ISSUE : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ci_start   = (state == ST_ISSUE);
      res_valid  = (state == ST_HOLD);
      busy       = (state != ST_IDLE) || not_empty;
      op_ready   = (count != FULL_COUNT);
      push       = op_valid && op_ready;
      capture    = ((state == ST_ISSUE) && ci_done) ||
                   ((state == ST_WAIT) && (ci_done || timeout_hit));
      pop        = capture;
      load_dataa = (state_nxt == ST_ISSUE) && (state != ST_ISSUE);
   end

   // ------------------------------------------------------ operand queue
   always_ff @(posedge clk) begin
      if (clk_en && push) begin
         mem[wr_ptr] <= op_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         ci_dataa    <= '0;
         res_data    <= '0;
         res_timeout <= 1'b0;
      end else if (clk_en) begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         // ci_dataa is only loaded on entry to ISSUE, so it stays put
         // for the whole time the unit is working on it.
         if (load_dataa) begin
            ci_dataa <= mem[rd_ptr];
         end
         if (capture) begin
            res_data    <= timeout_hit ? QNAN : ci_result;
            res_timeout <= timeout_hit;
         end else if ((state == ST_HOLD) && res_ready) begin
            res_timeout <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------ WAIT timeout
`ifdef CI_TIMEOUT_EN
   localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt;

   // The counter holds the number of completed WAIT cycles; the abort
   // fires in the WAIT cycle that would make it reach TIMEOUT_CYCLES.
   assign timeout_hit = (state == ST_WAIT) && !ci_done && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= '0;
      end else if (clk_en) begin
         if (state == ST_ISSUE) begin
            tmo_cnt <= '0;
         end else if ((state == ST_WAIT) && !ci_done) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_ci_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cordic_ci_master                                          |
// | Description : Directed self-checking bench for cordic_ci_master with a     |
// |               behavioural custom-instruction stub of programmable latency. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cordic_ci_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_data;
   logic        ci_clk_en;
   logic        ci_start;
   logic [31:0] ci_dataa;
   logic        ci_done;
   logic [31:0] ci_result;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_timeout;
   logic        busy;

   int          n_checks = 0;
   int          n_fail   = 0;

   // custom-instruction stub state
   logic        stub_on;
   int          stub_lat;
   int          stub_cnt;
   logic [31:0] stub_op;

   cordic_ci_master #(
      .DEPTH          (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clk_en      (clk_en),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_data     (op_data),
      .ci_clk_en   (ci_clk_en),
      .ci_start    (ci_start),
      .ci_dataa    (ci_dataa),
      .ci_done     (ci_done),
      .ci_result   (ci_result),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_timeout (res_timeout),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // The stub returns a fixed answer for the reference angle, otherwise x+1.
   function automatic logic [31:0] stub_map(input logic [31:0] a);
      return (a == 32'hBF45_1EB8) ? 32'h3F37_D0A2 : a + 32'd1;
   endfunction

   // Advance to the next falling edge and update the stub. ci_done rises
   // stub_lat enabled cycles after the cycle in which ci_start was seen.
   task automatic step();
      @(negedge clk);
      if (stub_on) begin
         ci_done = 1'b0;
         if (stub_cnt > 0 && ci_clk_en) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
               ci_done   = 1'b1;
               ci_result = stub_map(stub_op);
            end
         end else if (ci_start && ci_clk_en && stub_cnt == 0) begin
            stub_cnt = stub_lat;
            stub_op  = ci_dataa;
         end
      end
   endtask

   task automatic push_one(input logic [31:0] d);
      int guard = 0;
      while (!op_ready && guard < 50) begin
         step();
         guard++;
      end
      check("push_ready", {31'd0, op_ready}, 32'd1);
      op_valid = 1'b1;
      op_data  = d;
      step();
      op_valid = 1'b0;
   endtask

   task automatic wait_start(input int max, output int n);
      n = 0;
      while (!ci_start && n < max) begin
         step();
         n++;
      end
      check("start_seen", {31'd0, ci_start}, 32'd1);
   endtask

   task automatic wait_res(input int max, output int n, output int starts);
      n      = 0;
      starts = 0;
      while (!res_valid && n < max) begin
         step();
         n++;
         if (ci_start) starts++;
      end
      check("res_seen", {31'd0, res_valid}, 32'd1);
   endtask

   initial begin
      int          n;
      int          starts;
      int          acc;
      int          k;
      int          bad;
      logic        will_accept;
      logic        full_checked;
      logic [31:0] snap_data;
      logic [31:0] snap_dataa;
      logic [31:0] burst_in  [5];
      logic [31:0] burst_exp [5];

      burst_in  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
      burst_exp = '{32'h3F80_0001, 32'h4000_0001, 32'h4040_0001, 32'h4080_0001, 32'h40A0_0001};

      reset     = 1'b0;
      clk_en    = 1'b1;
      op_valid  = 1'b0;
      op_data   = '0;
      res_ready = 1'b0;
      ci_done   = 1'b0;
      ci_result = '0;
      stub_on   = 1'b1;
      stub_lat  = 4;
      stub_cnt  = 0;
      stub_op   = '0;

      // ---------------------------------------------- reset state
      step();
      step();
      check("rst_op_ready",  {31'd0, op_ready},    32'd1);
      check("rst_ci_start",  {31'd0, ci_start},    32'd0);
      check("rst_ci_dataa",  ci_dataa,             32'd0);
      check("rst_res_valid", {31'd0, res_valid},   32'd0);
      check("rst_res_data",  res_data,             32'd0);
      check("rst_res_tmo",   {31'd0, res_timeout}, 32'd0);
      check("rst_busy",      {31'd0, busy},        32'd0);
      check("ci_clk_en_on",  {31'd0, ci_clk_en},   32'd1);
      reset = 1'b1;
      step();

      // ---------------------------------------------- single operation
      push_one(32'hBF45_1EB8);
      check("single_busy_idle",  {31'd0, busy},     32'd1);
      check("single_no_start",   {31'd0, ci_start}, 32'd0);
      wait_start(10, n);
      check("single_start_lat",  n,        32'd1);
      check("single_dataa",      ci_dataa, 32'hBF45_1EB8);
      wait_res(20, n, starts);
      // done is high 4 cycles after the start cycle, result the cycle after
      check("single_res_lat",    n,        32'd5);
      check("single_one_start",  starts,   32'd0);
      check("single_res_data",   res_data, 32'h3F37_D0A2);
      check("single_res_tmo",    {31'd0, res_timeout}, 32'd0);
      step();
      step();
      check("single_hold_valid", {31'd0, res_valid}, 32'd1);
      check("single_hold_data",  res_data, 32'h3F37_D0A2);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("single_taken",      {31'd0, res_valid}, 32'd0);
      check("single_idle_busy",  {31'd0, busy},      32'd0);

      // ---------------------------------------------- burst into a full queue
      acc          = 0;
      full_checked = 1'b0;
      for (int c = 0; c < 60 && acc < 5; c++) begin
         op_valid    = 1'b1;
         op_data     = burst_in[acc];
         will_accept = op_ready;
         step();
         if (will_accept) acc++;
         if (acc == 4 && !full_checked) begin
            check("burst_full_ready", {31'd0, op_ready}, 32'd0);
            full_checked = 1'b1;
         end
      end
      op_valid = 1'b0;
      check("burst_all_accepted", acc, 32'd5);
      res_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 300 && k < 5; c++) begin
         if (res_valid) begin
            check($sformatf("burst_order_%0d", k), res_data, burst_exp[k]);
            k++;
         end
         step();
      end
      res_ready = 1'b0;
      check("burst_count", k, 32'd5);
      step();
      check("burst_drained", {31'd0, busy}, 32'd0);

      // ---------------------------------------------- back-pressure in HOLD
      push_one(32'h4100_0000);
      push_one(32'h4110_0000);
      wait_start(10, n);
      wait_res(20, n, starts);
      snap_data = res_data;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (res_data !== snap_data || !res_valid || ci_start) bad++;
      end
      check("bp_first_data", snap_data, 32'h4100_0001);
      check("bp_hold_stable", bad, 32'd0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("bp_next_start", {31'd0, ci_start}, 32'd1);
      check("bp_next_dataa", ci_dataa, 32'h4110_0000);
      wait_res(20, n, starts);
      check("bp_second_data", res_data, 32'h4110_0001);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;

      // ---------------------------------------------- clock-enable freeze in WAIT
      push_one(32'h4120_0000);
      wait_start(10, n);
      step();
      step();
      clk_en     = 1'b0;
      snap_dataa = ci_dataa;
      bad        = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (ci_clk_en || ci_start || res_valid || !busy || res_timeout ||
             ci_dataa !== snap_dataa || res_data !== 32'h4110_0001 || !op_ready) bad++;
      end
      check("freeze_outputs", bad, 32'd0);
      check("freeze_dataa", snap_dataa, 32'h4120_0000);
      clk_en = 1'b1;
      wait_res(20, n, starts);
      check("freeze_resume_lat", n, 32'd3);
      check("freeze_res_data", res_data, 32'h4120_0001);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;

      // ---------------------------------------------- reset mid-operation
      stub_lat = 8;
      push_one(32'h4130_0000);
      push_one(32'h4140_0000);
      push_one(32'h4150_0000);
      step();
      step();
      check("mid_busy", {31'd0, busy}, 32'd1);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_op_ready",  {31'd0, op_ready},    32'd1);
      check("mid_rst_ci_start",  {31'd0, ci_start},    32'd0);
      check("mid_rst_ci_dataa",  ci_dataa,             32'd0);
      check("mid_rst_res_valid", {31'd0, res_valid},   32'd0);
      check("mid_rst_res_data",  res_data,             32'd0);
      check("mid_rst_busy",      {31'd0, busy},        32'd0);
      step();
      reset = 1'b1;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (res_valid || ci_start || busy) bad++;
      end
      check("late_done_ignored", bad, 32'd0);
      check("late_res_data", res_data, 32'd0);

      // ---------------------------------------------- unit never answers
      stub_on  = 1'b0;
      stub_cnt = 0;
      ci_done  = 1'b0;
      push_one(32'h4160_0000);
      wait_start(10, n);
`ifdef CI_TIMEOUT_EN
      wait_res(40, n, starts);
      // ISSUE cycle, then 8 WAIT cycles, result valid the cycle after
      check("tmo_latency", n, 32'd9);
      check("tmo_res_data", res_data, 32'h7FC0_0000);
      check("tmo_flag", {31'd0, res_timeout}, 32'd1);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("tmo_flag_clear", {31'd0, res_timeout}, 32'd0);
      check("tmo_taken", {31'd0, res_valid}, 32'd0);
`else
      bad = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (res_valid || res_timeout || ci_start) bad++;
      end
      check("no_tmo_stays_wait", bad, 32'd0);
      check("no_tmo_busy", {31'd0, busy}, 32'd1);
      ci_result = 32'h3F80_0000;
      ci_done   = 1'b1;
      step();
      ci_done   = 1'b0;
      check("no_tmo_late_valid", {31'd0, res_valid}, 32'd1);
      check("no_tmo_late_data", res_data, 32'h3F80_0000);
      check("no_tmo_flag", {31'd0, res_timeout}, 32'd0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
`endif
      step();
      check("final_idle", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
